// File: rtl/psum_init_src_sel.sv
// Picks per-lane accumulator init values (sign-extended bias or OBUF partial sum) for each OBUF read.
// Latency: obuf_rd_req at cycle t gives init_valid at t+OBUF_RD_LAT+1; one beat per cycle sustained.
// Backpressure: FIFO_DEPTH-entry output FIFO on init_valid/init_ready; a return into a full FIFO with no pop is dropped and flagged.
module psum_init_src_sel #(
    parameter int ARRAY_N     = 32,
    parameter int DATA_W      = 64,
    parameter int BIAS_W      = 32,
    parameter int OBUF_RD_LAT = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done,
    input  logic                        obuf_bias_sel,
    input  logic                        obuf_rd_req,
    input  logic [ARRAY_N*DATA_W-1:0]   obuf_rd_data,
    input  logic                        bias_ld_v,
    input  logic [ARRAY_N*BIAS_W-1:0]   bias_ld_data,
    output logic [ARRAY_N*DATA_W-1:0]   init_data,
    output logic                        init_src,
    output logic                        init_valid,
    input  logic                        init_ready,
    output logic                        fifo_overflow,
    output logic                        bias_unloaded_err,
    output logic [15:0]                 bias_beat_cnt,
    output logic [15:0]                 obuf_beat_cnt
);

    localparam int VEC_W = ARRAY_N * DATA_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ---------------- tag pipeline ----------------
    logic [OBUF_RD_LAT-1:0] tag_v;
    logic [OBUF_RD_LAT-1:0] tag_sel;
    logic                   ret_v;
    logic                   ret_sel;

    // Carry {req, sel} alongside the OBUF read so the select lines up with the returning data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v   <= '0;
            tag_sel <= '0;
        end else begin
            tag_v[0]   <= obuf_rd_req;
            tag_sel[0] <= obuf_bias_sel;
            for (int i = 1; i < OBUF_RD_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_sel[i] <= tag_sel[i-1];
            end
        end
    end

    assign ret_v   = tag_v[OBUF_RD_LAT-1];
    assign ret_sel = tag_sel[OBUF_RD_LAT-1];

    // ---------------- bias register ----------------
    logic [ARRAY_N*BIAS_W-1:0] bias_q;
    logic                      bias_loaded;
    logic [VEC_W-1:0]          bias_ext;

    // Bias vector is kept across done; only the "loaded" qualifier is cleared by done.
    always_ff @(posedge clk) begin
        if (reset) begin
            bias_q      <= '0;
            bias_loaded <= 1'b0;
        end else begin
            if (bias_ld_v) begin
                bias_q <= bias_ld_data;
            end
            if (bias_ld_v) begin
                bias_loaded <= 1'b1;
            end else if (done) begin
                bias_loaded <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
        logic signed [BIAS_W-1:0] lane_bias;
        assign lane_bias                    = bias_q[g*BIAS_W +: BIAS_W];
        assign bias_ext[g*DATA_W +: DATA_W] = DATA_W'(lane_bias);
    end

    logic [VEC_W-1:0] beat_data;
    assign beat_data = ret_sel ? obuf_rd_data : bias_ext;

    // ---------------- output FIFO ----------------
    logic [VEC_W-1:0] fifo_dat [FIFO_DEPTH];
    logic             fifo_src [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign init_valid = (count != '0);
    assign pop        = init_valid && init_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push       = ret_v && (!full || pop);
    assign init_data  = fifo_dat[rd_ptr];
    assign init_src   = fifo_src[rd_ptr];

    // Storage is data-only; validity comes from count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr] <= beat_data;
            fifo_src[wr_ptr] <= ret_sel;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // ---------------- status ----------------
    // Sticky error flags; bias misuse is flagged even though the beat is still written.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_overflow     <= 1'b0;
            bias_unloaded_err <= 1'b0;
        end else begin
            if (ret_v && full && !pop) begin
                fifo_overflow <= 1'b1;
            end
            if (ret_v && !ret_sel && !bias_loaded) begin
                bias_unloaded_err <= 1'b1;
            end
        end
    end

    // Per-source beat counters, saturating; done takes priority over a same-cycle push.
    always_ff @(posedge clk) begin
        if (reset || done) begin
            bias_beat_cnt <= '0;
            obuf_beat_cnt <= '0;
        end else if (push) begin
            if (ret_sel) begin
                if (obuf_beat_cnt != 16'hFFFF) obuf_beat_cnt <= obuf_beat_cnt + 16'd1;
            end else begin
                if (bias_beat_cnt != 16'hFFFF) bias_beat_cnt <= bias_beat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/psum_init_src_sel.md
Name: psum_init_src_sel

Overview:
- Downstream consumer of the registered obuf/bias select flag.
- For every output-buffer read issued to the MXV accumulator path, it chooses the accumulator initial value for each lane:
  - the bias vector, sign-extended, when the flag is 0;
  - the partial sum returned by OBUF when the flag is 1.
- The flag is latched at read-issue time and kept aligned with the OBUF read latency.
- Results are buffered in a small FIFO with a valid/ready handshake toward the accumulator array.

Parameters:
- ARRAY_N, 32, number of lanes.
- DATA_W, 64, per-lane partial-sum width.
- BIAS_W, 32, per-lane bias width (BIAS_W <= DATA_W).
- OBUF_RD_LAT, 2, cycles from obuf_rd_req to obuf_rd_data being valid (>= 1).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- done  in  1  end-of-instruction pulse; clears counters and bias_loaded
- obuf_bias_sel  in  1  1 = use OBUF partial sum, 0 = use bias
- obuf_rd_req  in  1  OBUF read issued this cycle
- obuf_rd_data  in  ARRAY_N*DATA_W  OBUF read data, valid OBUF_RD_LAT cycles after req
- bias_ld_v  in  1  load bias vector
- bias_ld_data  in  ARRAY_N*BIAS_W  bias vector, lane 0 in LSBs
- init_data  out  ARRAY_N*DATA_W  accumulator initial values (FIFO head)
- init_src  out  1  select tag of FIFO head (1 = obuf, 0 = bias)
- init_valid  out  1  FIFO non-empty
- init_ready  in  1  consumer accepts head
- fifo_overflow  out  1  sticky: a returning beat was dropped
- bias_unloaded_err  out  1  sticky: bias used before any bias_ld_v since reset/done
- bias_beat_cnt  out  16  beats issued with bias source since reset/done
- obuf_beat_cnt  out  16  beats issued with obuf source since reset/done

Behaviour:
- Reset values:
  - init_valid = 0, fifo_overflow = 0, bias_unloaded_err = 0.
  - Both counters = 0.
  - bias register = 0, bias_loaded = 0.
  - Tag pipeline cleared; FIFO empty (init_data/init_src are don't-care while init_valid = 0).
- Reset mid-operation: in-flight tags and FIFO contents are discarded, and no beat is emitted afterwards for pre-reset requests.
- Tag pipeline:
  - Shift register of depth OBUF_RD_LAT; each stage holds {v, sel}.
  - Stage 0 loads {obuf_rd_req, obuf_bias_sel} every cycle.
  - A beat "returns" in the cycle the last stage has v = 1; obuf_rd_data is sampled in that same cycle.
- Beat formation on return:
  - sel = 1: lane i = obuf_rd_data lane i.
  - sel = 0: lane i = sign-extend(bias register lane i) to DATA_W.
  - The bias register value used is the one held in the return cycle. A bias_ld_v in the same cycle takes effect the next cycle.
- Bias load:
  - bias_ld_v writes the bias register at the clock edge and sets bias_loaded.
  - done clears bias_loaded but not the register.
  - A sel = 0 return with bias_loaded = 0 sets bias_unloaded_err; the beat is still written.
- FIFO:
  - Push on return if not full. Pop when init_valid && init_ready.
  - Push and pop in the same cycle are both allowed, including when full: the pop frees the slot, so no drop occurs.
  - Return while full with no pop: the beat is dropped and fifo_overflow is set (sticky until reset).
  - First-word latency: obuf_rd_req at cycle t gives init_valid at cycle t+OBUF_RD_LAT+1.
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- Counters:
  - Increment on each pushed beat, by source.
  - Saturate at 0xFFFF.
  - done clears both; if a push and done happen together, done wins.
- done does not flush the tag pipeline or the FIFO.
- Back-to-back obuf_rd_req every cycle is supported: one return per cycle.

Test Plan:
- Basic latency: OBUF_RD_LAT = 2, bias loaded with lane values 0xFFFFFFFE; req with sel = 0 at cycle 10 -> init_valid at cycle 13, every lane = 0xFFFFFFFFFFFFFFFE, init_src = 0, bias_beat_cnt = 1.
- Sel alignment: 4 back-to-back reqs with sel = 0,1,1,0, obuf data lane 0 = 0x11,0x22,0x33,0x44, init_ready = 1 -> output lane 0 = bias, 0x22, 0x33, bias in order; counters 2/2.
- Overflow: init_ready = 0, 6 reqs with FIFO_DEPTH = 4 -> 4 entries held, fifo_overflow = 1 from the 5th return; drain then yields the first 4 beats only.
- Full with simultaneous pop: FIFO full, init_ready = 1 in the same cycle as a return -> no overflow, count stays 4.
- Bias update race: bias_ld_v with new value in the same cycle as a sel = 0 return -> beat carries the old bias; the next sel = 0 beat carries the new bias.
- Reset/done: reset asserted with 2 tags in flight -> no init_valid afterwards and all outputs at reset values. Separately, done then sel = 0 req with no bias load -> bias_unloaded_err = 1.
